// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - requester and data-memory signal bundle for dm_arbiter
// Purpose : groups both requester handshakes and the data-memory bus.
// Modports: slave  - arbiter view (requests in, acks/read data/memory strobes out)
//           master - environment view (requesters plus the memory itself)
interface dm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              err0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic              err1;
  logic [DATA_W-1:0] rdata1;

  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWriteData;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] MemReadData;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  MemReadData,
    output ack0, err0, rdata0,
    output ack1, err1, rdata1,
    output MemAddr, MemWriteData, MemWrite, MemRead
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output MemReadData,
    input  ack0, err0, rdata0,
    input  ack1, err1, rdata1,
    input  MemAddr, MemWriteData, MemWrite, MemRead
  );
endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port round-robin arbiter/sequencer for the data memory
// Purpose: serialises 32-bit word accesses from port 0 (CPU) and port 1 (DMA),
//          pulses the memory strobe for one cycle, returns a one-cycle ack.
// Ports  : clk, rst_n (sync, active-low)
//          bus  - dm_arbiter_if.slave (requester handshakes + memory bus)
//          busy - high whenever the FSM is not IDLE
//          gnt  - port currently or most recently granted
module dm_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  dm_arbiter_if.slave bus,
  output logic        busy,
  output logic        gnt
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  state_t            state_q, state_d;
  // last_q is both the round-robin pointer and the active winner after a grant
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              ack0_q, ack0_d, err0_q, err0_d;
  logic              ack1_q, ack1_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_read_q, mem_read_d;

  logic              pick;
  logic              pick_we;
  logic              pick_bad;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;

  // Lone requester wins; a tie goes to the port not served last.
  assign pick       = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
  assign pick_we    = pick ? bus.we1 : bus.we0;
  assign pick_addr  = pick ? bus.addr1 : bus.addr0;
  assign pick_wdata = pick ? bus.wdata1 : bus.wdata0;
  // Full-width compare so large addresses never alias into the array.
  assign pick_bad   = (pick_addr[1:0] != 2'b00) || (pick_addr > LAST_WORD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      ack0_q      <= 1'b0;
      err0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      ack0_q      <= ack0_d;
      err0_q      <= err0_d;
      ack1_q      <= ack1_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  // Outputs are registered, so each *_d below is the value seen during the
  // state being entered (strobes during ACCESS, ack/err during DONE).
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    we_d        = we_q;
    ack0_d      = 1'b0;
    err0_d      = 1'b0;
    ack1_d      = 1'b0;
    err1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          last_d = pick;
          we_d   = pick_we;
          if (pick_bad) begin
            // Rejected without touching memory: ack+err next cycle.
            state_d = DONE;
            ack0_d  = ~pick;
            err0_d  = ~pick;
            ack1_d  = pick;
            err1_d  = pick;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = pick_addr;
            if (pick_we) begin
              mem_write_d = 1'b1;
              mem_wdata_d = pick_wdata;
            end else begin
              mem_read_d = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // MemReadData settled a full cycle ago, at the end of ACCESS.
        if (!we_q) begin
          if (last_q) rdata1_d = bus.MemReadData;
          else        rdata0_d = bus.MemReadData;
        end
        ack0_d  = ~last_q;
        ack1_d  = last_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.ack0         = ack0_q;
  assign bus.err0         = err0_q;
  assign bus.rdata0       = rdata0_q;
  assign bus.ack1         = ack1_q;
  assign bus.err1         = err1_q;
  assign bus.rdata1       = rdata1_q;
  assign bus.MemAddr      = mem_addr_q;
  assign bus.MemWriteData = mem_wdata_q;
  assign bus.MemWrite     = mem_write_q;
  assign bus.MemRead      = mem_read_q;
  assign busy             = busy_q;
  assign gnt              = last_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed scoreboard bench for dm_arbiter
module tb_dm_arbiter;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  typedef struct {
    int port;
    int cyc;
  } hist_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic gnt;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t  q0[$];
  exp_t  q1[$];
  hist_t hist[$];
  exp_t  mon_e;
  hist_t mon_h;
  int    wr_cnt = 0;
  int    rd_cnt = 0;
  logic [31:0] wr_addr = '0;
  logic [7:0]  mem [0:127];

  dm_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dm_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(128)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .busy (busy),
    .gnt  (gnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Big-endian byte memory: writes commit on negedge, reads update on posedge.
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (a <= 32'd124) return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    if (bus.MemWrite && bus.MemAddr <= 32'd124) begin
      mem[bus.MemAddr]   <= bus.MemWriteData[31:24];
      mem[bus.MemAddr+1] <= bus.MemWriteData[23:16];
      mem[bus.MemAddr+2] <= bus.MemWriteData[15:8];
      mem[bus.MemAddr+3] <= bus.MemWriteData[7:0];
    end
  end

  always @(posedge clk) begin
    if (bus.MemRead) bus.MemReadData <= rd_word(bus.MemAddr);
  end

  // Monitor: strobe bookkeeping and scoreboard pops on every ack.
  always @(negedge clk) begin
    if (bus.MemWrite) begin
      wr_cnt++;
      wr_addr = bus.MemAddr;
    end
    if (bus.MemRead) rd_cnt++;
    if (bus.MemWrite || bus.MemRead) chk("strobe_exclusive", {31'b0, bus.MemWrite & bus.MemRead}, 32'd0);
    if (bus.ack0 || bus.ack1) chk("ack_one_port", {31'b0, bus.ack0 & bus.ack1}, 32'd0);
    if (bus.ack0) begin
      mon_h.port = 0;
      mon_h.cyc  = cyc;
      hist.push_back(mon_h);
      chk("ack0_expected", {31'b0, q0.size() != 0}, 32'd1);
      if (q0.size() != 0) begin
        mon_e = q0.pop_front();
        chk("err0", {31'b0, bus.err0}, {31'b0, mon_e.err});
        chk("rdata0", bus.rdata0, mon_e.rdata);
        if (mon_e.cyc >= 0) chk("ack0_latency", cyc, mon_e.cyc);
      end
    end
    if (bus.ack1) begin
      mon_h.port = 1;
      mon_h.cyc  = cyc;
      hist.push_back(mon_h);
      chk("ack1_expected", {31'b0, q1.size() != 0}, 32'd1);
      if (q1.size() != 0) begin
        mon_e = q1.pop_front();
        chk("err1", {31'b0, bus.err1}, {31'b0, mon_e.err});
        chk("rdata1", bus.rdata1, mon_e.rdata);
        if (mon_e.cyc >= 0) chk("ack1_latency", cyc, mon_e.cyc);
      end
    end
  end

  // Called #1 after a posedge; lat is the cycle distance from this drive
  // point to ack visibility (-1 = not checked). Returns #1 after the
  // posedge that sampled ack, with req dropped.
  task automatic issue(input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic xerr,
                       input logic [31:0] xrd, input int lat);
    exp_t e;
    int   n;
    logic seen;
    e.err   = xerr;
    e.rdata = xrd;
    e.cyc   = (lat < 0) ? -1 : cyc + lat;
    if (p == 0) begin
      q0.push_back(e);
      bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      q1.push_back(e);
      bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(negedge clk);
      n++;
      seen = (p == 0) ? bus.ack0 : bus.ack1;
    end
    chk($sformatf("ack_timeout_p%0d", p), {31'b0, seen}, 32'd1);
    @(posedge clk); #1;
    if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  task automatic check_reset(input string t);
    chk({t, "_ack0"}, {31'b0, bus.ack0}, 32'd0);
    chk({t, "_ack1"}, {31'b0, bus.ack1}, 32'd0);
    chk({t, "_err0"}, {31'b0, bus.err0}, 32'd0);
    chk({t, "_err1"}, {31'b0, bus.err1}, 32'd0);
    chk({t, "_rdata0"}, bus.rdata0, 32'd0);
    chk({t, "_rdata1"}, bus.rdata1, 32'd0);
    chk({t, "_memaddr"}, bus.MemAddr, 32'd0);
    chk({t, "_memwdata"}, bus.MemWriteData, 32'd0);
    chk({t, "_memwrite"}, {31'b0, bus.MemWrite}, 32'd0);
    chk({t, "_memread"}, {31'b0, bus.MemRead}, 32'd0);
    chk({t, "_busy"}, {31'b0, busy}, 32'd0);
    chk({t, "_gnt"}, {31'b0, gnt}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h;
    int w0;
    int r0;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'hA5;
    rst_n = 1'b0;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1;

    // Write then read back at addr 8 on port 0.
    w0 = wr_cnt;
    issue(0, 1'b1, 32'd8, 32'h11223344, 1'b0, 32'h0, 3);
    chk("t1_write_pulses", wr_cnt - w0, 32'd1);
    chk("t1_write_addr", wr_addr, 32'd8);
    issue(0, 1'b0, 32'd8, 32'h0, 1'b0, 32'h11223344, 3);

    // Continuous tie from reset: grants alternate 0,1,0,1 every 4 cycles.
    do_reset();
    h = hist.size();
    fork
      begin
        issue(0, 1'b0, 32'd0, 32'h0, 1'b0, 32'hA5A4A7A6, 3);
        issue(0, 1'b0, 32'd0, 32'h0, 1'b0, 32'hA5A4A7A6, -1);
      end
      begin
        issue(1, 1'b0, 32'd4, 32'h0, 1'b0, 32'hA1A0A3A2, 7);
        issue(1, 1'b0, 32'd4, 32'h0, 1'b0, 32'hA1A0A3A2, -1);
      end
    join
    chk("tie_ack_count", hist.size() - h, 32'd4);
    for (int i = 0; i < 4 && h + i < hist.size(); i++) begin
      chk($sformatf("tie_order_%0d", i), hist[h+i].port, i % 2);
      if (i > 0) chk($sformatf("tie_gap_%0d", i), hist[h+i].cyc - hist[h+i-1].cyc, 32'd4);
    end

    // Misaligned read on port 1: immediate error, no memory read.
    r0 = rd_cnt;
    issue(1, 1'b0, 32'd6, 32'h0, 1'b1, 32'hA1A0A3A2, 1);
    chk("t3_no_memread", rd_cnt - r0, 32'd0);
    chk("t3_gnt", {31'b0, gnt}, 32'd1);

    // Range boundary on port 0.
    r0 = rd_cnt;
    issue(0, 1'b0, 32'd128, 32'h0, 1'b1, 32'hA5A4A7A6, 1);
    chk("t4_oob_no_memread", rd_cnt - r0, 32'd0);
    issue(0, 1'b0, 32'd124, 32'h0, 1'b0, 32'hD9D8DBDA, 3);
    chk("t4_gnt", {31'b0, gnt}, 32'd0);

    // Port 1 write in flight, port 0 raises req during ACCESS.
    h = hist.size();
    fork
      issue(1, 1'b1, 32'd12, 32'hCAFEF00D, 1'b0, 32'hA1A0A3A2, 3);
      begin
        @(posedge clk); #1;
        chk("t5_busy_access", {31'b0, busy}, 32'd1);
        issue(0, 1'b0, 32'd12, 32'h0, 1'b0, 32'hCAFEF00D, 6);
      end
    join
    chk("t5_ack_count", hist.size() - h, 32'd2);
    if (hist.size() - h >= 2) begin
      chk("t5_first_port", hist[h].port, 32'd1);
      chk("t5_second_port", hist[h+1].port, 32'd0);
      chk("t5_gap", hist[h+1].cyc - hist[h].cyc, 32'd4);
    end

    // Reset during CAPTURE of a port 0 read.
    h = hist.size();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_busy_capture", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("t6");
    bus.req0 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_no_ack", hist.size() - h, 32'd0);
    @(posedge clk); #1;
    h = hist.size();
    fork
      issue(0, 1'b0, 32'd4, 32'h0, 1'b0, 32'hA1A0A3A2, 3);
      issue(1, 1'b0, 32'd0, 32'h0, 1'b0, 32'hA5A4A7A6, 7);
    join
    chk("t6_tie_count", hist.size() - h, 32'd2);
    if (hist.size() - h >= 2) begin
      chk("t6_tie_first", hist[h].port, 32'd0);
      chk("t6_tie_second", hist[h+1].port, 32'd1);
    end

    repeat (2) @(posedge clk);
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
